vga_timing_gen: RTL and testbench

Pixel-timing source for the 640x480@60 Hz display path. Drives `DrawX`/`DrawY`/`blank` into the sprite and background renderers, which do a ROM lookup, a palette lookup and a registered colour output. It generates `hs`/`vs` delayed by a programmable number of cycles so sync stays aligned with that renderer pipeline. It also gives game logic a once-per-frame tick and a frame counter for the vblank update window.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/sync_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants for the 640x480@60 Hz display path, shared by the timing
// generator, the renderers and the game-state logic.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam coord_t H_VISIBLE = 10'd640;
    localparam coord_t H_FP      = 10'd16;
    localparam coord_t H_SYNC    = 10'd96;
    localparam coord_t H_BP      = 10'd48;
    localparam coord_t H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam coord_t V_VISIBLE = 10'd480;
    localparam coord_t V_FP      = 10'd10;
    localparam coord_t V_SYNC    = 10'd2;
    localparam coord_t V_BP      = 10'd33;
    localparam coord_t V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Sync windows are [START, END): END is the first count after the pulse.
    localparam coord_t H_SYNC_START = H_VISIBLE + H_FP;
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam coord_t V_SYNC_START = V_VISIBLE + V_FP;
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC;

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi_excl);
        return (v >= lo) && (v < hi_excl);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a programmable reset value, used to align
// the sync outputs with the renderer pipeline.
module sync_delay_line #(
    parameter int unsigned DEPTH     = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic vga_clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused;
        assign w_unused = vga_clk ^ reset;
        assign o_q      = i_d;
    end else begin : g_shift
        logic [DEPTH-1:0] r_stages;

        always_ff @(posedge vga_clk) begin
            if (reset) begin
                r_stages <= {DEPTH{RESET_VAL}};
            end else begin
                r_stages[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stages[i] <= r_stages[i-1];
                end
            end
        end

        assign o_q = r_stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz pixel timing: pixel/line counters, registered blank and
// frame tick, frame counter, and sync outputs delayed to match the renderers.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned SYNC_DELAY  = 2,
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    output logic [9:0]             DrawX,
    output logic [9:0]             DrawY,
    output logic                   blank,
    output logic                   hs,
    output logic                   vs,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    coord_t                 r_draw_x;
    coord_t                 r_draw_y;
    logic                   r_blank;
    logic                   r_hs_raw;
    logic                   r_vs_raw;
    logic                   r_frame_tick;
    logic [FRAME_CNT_W-1:0] r_frame_count;

    coord_t w_x_nxt;
    coord_t w_y_nxt;
    logic   w_x_wrap;
    logic   w_y_wrap;
    logic   w_blank_nxt;
    logic   w_hs_raw_nxt;
    logic   w_vs_raw_nxt;
    logic   w_tick_nxt;

    // Decoding from the next-state counters keeps the registered flags aligned
    // with the DrawX/DrawY they describe.
    always_comb begin
        w_x_wrap = (r_draw_x == H_TOTAL - 10'd1);
        w_y_wrap = (r_draw_y == V_TOTAL - 10'd1);
        w_x_nxt  = w_x_wrap ? '0 : r_draw_x + 10'd1;
        w_y_nxt  = r_draw_y;
        if (w_x_wrap) begin
            w_y_nxt = w_y_wrap ? '0 : r_draw_y + 10'd1;
        end
        w_blank_nxt  = (w_x_nxt < H_VISIBLE) && (w_y_nxt < V_VISIBLE);
        w_hs_raw_nxt = !in_window(w_x_nxt, H_SYNC_START, H_SYNC_END);
        w_vs_raw_nxt = !in_window(w_y_nxt, V_SYNC_START, V_SYNC_END);
        w_tick_nxt   = (w_x_nxt == '0) && (w_y_nxt == V_VISIBLE);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_draw_x      <= '0;
            r_draw_y      <= '0;
            r_blank       <= 1'b0;
            r_hs_raw      <= 1'b1;
            r_vs_raw      <= 1'b1;
            r_frame_tick  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_draw_x     <= w_x_nxt;
            r_draw_y     <= w_y_nxt;
            r_blank      <= w_blank_nxt;
            r_hs_raw     <= w_hs_raw_nxt;
            r_vs_raw     <= w_vs_raw_nxt;
            r_frame_tick <= w_tick_nxt;
            if (r_frame_tick) begin
                r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
            end
        end
    end

    sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (1'b1)
    ) u_hs_delay (
        .vga_clk (vga_clk),
        .reset   (reset),
        .i_d     (r_hs_raw),
        .o_q     (hs)
    );

    sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (1'b1)
    ) u_vs_delay (
        .vga_clk (vga_clk),
        .reset   (reset),
        .i_d     (r_vs_raw),
        .o_q     (vs)
    );

    assign DrawX       = r_draw_x;
    assign DrawY       = r_draw_y;
    assign blank       = r_blank;
    assign frame_tick  = r_frame_tick;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default build (delay 2) and a
// zero-delay build run side by side against a linear pixel-index model.
module tb_vga_timing_gen;

    localparam int D       = 2;
    localparam int H_TOT   = 800;
    localparam int V_TOT   = 525;
    localparam int F_TOT   = H_TOT * V_TOT;
    localparam int TICK_P  = 480 * H_TOT;
    localparam logic [39:0] RST_ONE = {10'd0, 10'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1};
    localparam logic [79:0] RST_VEC = {RST_ONE, RST_ONE};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]  x2, y2, x0, y0;
    logic        blank2, hs2, vs2, tick2, blank0, hs0, vs0, tick0;
    logic [15:0] cnt2, cnt0;

    vga_timing_gen #(.SYNC_DELAY(D), .FRAME_CNT_W(16)) u_d2 (
        .vga_clk(clk), .reset(reset), .DrawX(x2), .DrawY(y2), .blank(blank2),
        .hs(hs2), .vs(vs2), .frame_tick(tick2), .frame_count(cnt2)
    );

    vga_timing_gen #(.SYNC_DELAY(0), .FRAME_CNT_W(16)) u_d0 (
        .vga_clk(clk), .reset(reset), .DrawX(x0), .DrawY(y0), .blank(blank0),
        .hs(hs0), .vs(vs0), .frame_tick(tick0), .frame_count(cnt0)
    );

    int n_pass = 0;
    int n_total = 0;

    // Model: position is a linear pixel index 0..F_TOT-1; sync history is a
    // per-cycle record of the undelayed sync level, newest in bit 0.
    int          m_p;
    logic        m_blank, m_tick;
    logic [15:0] m_cnt;
    logic [7:0]  m_hq, m_vq;

    bit          j_req = 1'b0;
    int          j_p;
    bit          j_cnt_en;
    logic [15:0] j_cnt;
    logic [9:0]  jx, jy;
    logic [15:0] jc;

    function automatic int nxt(input int p);
        return (p + 1) % F_TOT;
    endfunction
    function automatic logic hs_lvl(input int p);
        return !((p % H_TOT) >= 656 && (p % H_TOT) < 752);
    endfunction
    function automatic logic vs_lvl(input int p);
        return !((p / H_TOT) >= 490 && (p / H_TOT) < 492);
    endfunction
    function automatic logic vis(input int p);
        return ((p % H_TOT) < 640) && ((p / H_TOT) < 480);
    endfunction
    function automatic int cur_p();
        return j_req ? j_p : m_p;
    endfunction
    function automatic logic [9:0] ex();
        return 10'(m_p % H_TOT);
    endfunction
    function automatic logic [9:0] ey();
        return 10'(m_p / H_TOT);
    endfunction
    function automatic logic [79:0] obs_vec();
        return {x2, y2, blank2, tick2, cnt2, hs2, vs2, x0, y0, blank0, tick0, cnt0, hs0, vs0};
    endfunction
    function automatic logic [79:0] exp_vec();
        return {ex(), ey(), m_blank, m_tick, m_cnt, m_hq[D], m_vq[D],
                ex(), ey(), m_blank, m_tick, m_cnt, m_hq[0], m_vq[0]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_p     <= 0;
            m_blank <= 1'b0;
            m_tick  <= 1'b0;
            m_cnt   <= '0;
            m_hq    <= '1;
            m_vq    <= '1;
        end else begin
            m_p     <= nxt(cur_p());
            m_blank <= vis(nxt(cur_p()));
            m_tick  <= (nxt(cur_p()) == TICK_P);
            m_cnt   <= ((j_req && j_cnt_en) ? j_cnt : m_cnt) + 16'(m_tick);
            m_hq    <= {m_hq[6:0], hs_lvl(nxt(cur_p()))};
            m_vq    <= {m_vq[6:0], vs_lvl(nxt(cur_p()))};
        end
    end

    // Move both DUTs' counters to pixel index p (saves running whole frames).
    task automatic jump(input int p, input bit set_cnt, input logic [15:0] cnt);
        @(negedge clk);
        jx = 10'(p % H_TOT);
        jy = 10'(p / H_TOT);
        jc = cnt;
        force u_d2.r_draw_x = jx;
        force u_d2.r_draw_y = jy;
        force u_d0.r_draw_x = jx;
        force u_d0.r_draw_y = jy;
        release u_d2.r_draw_x;
        release u_d2.r_draw_y;
        release u_d0.r_draw_x;
        release u_d0.r_draw_y;
        if (set_cnt) begin
            force u_d2.r_frame_count = jc;
            force u_d0.r_frame_count = jc;
            release u_d2.r_frame_count;
            release u_d0.r_frame_count;
        end
        j_p = p;
        j_cnt_en = set_cnt;
        j_cnt = cnt;
        j_req = 1'b1;
        @(posedge clk);
        #1 j_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec() !== RST_VEC)
                $display("FAIL reset_state: got %h expected %h", obs_vec(), RST_VEC);
            else n_pass++;
        end
    endtask

    task automatic test_first_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({x2, y2, blank2} !== {10'd1, 10'd0, 1'b1})
            $display("FAIL first_cycle: got x=%0d y=%0d blank=%b expected x=1 y=0 blank=1",
                     x2, y2, blank2);
        else n_pass++;
    endtask

    task automatic test_line_sweep();
        int fall_x = -1, rise_x = -1, low = 0, bcnt = 0, bfirst = -1, blast = -1;
        logic prev_hs = hs2;
        for (int i = 0; i < 11 * H_TOT; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL line_model t=%0t: got %h expected %h", $time, obs_vec(), exp_vec());
            else n_pass++;
            if (y2 == 10'd10) begin
                if (prev_hs && !hs2) fall_x = int'(x2);
                if (!prev_hs && hs2) rise_x = int'(x2);
                if (!hs2) low++;
                if (blank2) begin
                    bcnt++;
                    if (bfirst < 0) bfirst = int'(x2);
                    blast = int'(x2);
                end
            end
            prev_hs = hs2;
        end
        n_total++;
        if (fall_x != 658) $display("FAIL hs_fall_x: got %0d expected 658", fall_x);
        else n_pass++;
        n_total++;
        if (rise_x != 754) $display("FAIL hs_rise_x: got %0d expected 754", rise_x);
        else n_pass++;
        n_total++;
        if (low != 96) $display("FAIL hs_low_cycles: got %0d expected 96", low);
        else n_pass++;
        n_total++;
        if ({bcnt, bfirst, blast} != {32'd640, 32'd0, 32'd639})
            $display("FAIL blank_line10: got count=%0d first=%0d last=%0d expected 640/0/639",
                     bcnt, bfirst, blast);
        else n_pass++;
    endtask

    task automatic test_frame_sweep();
        int ticks = 0, tick_x = -1, tick_y = -1, max_x = 0, max_y = 0;
        int vlow2 = 0, vlow0 = 0, vf2x = -1, vf2y = -1, vf0x = -1, vf0y = -1, vblank = 0;
        logic [15:0] cnt_at_tick = 16'hxxxx, cnt_after = 16'hxxxx;
        logic wrap_seen = 1'b0, wrap_ok = 1'b0, prev_last = 1'b0;
        for (int seg = 0; seg < 3; seg++) begin
            jump((seg == 0 ? 479 : (seg == 1 ? 489 : 523)) * H_TOT + 100, 1'b0, 16'd0);
            for (int i = 0; i < (seg == 0 ? 1505 : (seg == 1 ? 2400 : 1600)); i++) begin
                @(negedge clk);
                n_total++;
                if (obs_vec() !== exp_vec())
                    $display("FAIL frame_model t=%0t: got %h expected %h",
                             $time, obs_vec(), exp_vec());
                else n_pass++;
                if (int'(x2) > max_x) max_x = int'(x2);
                if (int'(y2) > max_y) max_y = int'(y2);
                if (tick2) begin
                    ticks++;
                    tick_x = int'(x2);
                    tick_y = int'(y2);
                    cnt_at_tick = cnt2;
                end
                if (x2 == 10'd1 && y2 == 10'd480) cnt_after = cnt2;
                if (!vs2) begin
                    if (vf2x < 0) begin vf2x = int'(x2); vf2y = int'(y2); end
                    vlow2++;
                end
                if (!vs0) begin
                    if (vf0x < 0) begin vf0x = int'(x2); vf0y = int'(y2); end
                    vlow0++;
                end
                if (y2 >= 10'd480 && blank2) vblank++;
                if (prev_last) begin
                    wrap_seen = 1'b1;
                    wrap_ok = (x2 == 10'd0 && y2 == 10'd0 && blank2);
                end
                prev_last = (x2 == 10'd799 && y2 == 10'd524);
            end
        end
        n_total++;
        if ({ticks, tick_x, tick_y} != {32'd1, 32'd0, 32'd480})
            $display("FAIL frame_tick: got n=%0d at (%0d,%0d) expected 1 at (0,480)",
                     ticks, tick_x, tick_y);
        else n_pass++;
        n_total++;
        if ({cnt_at_tick, cnt_after} !== {16'd0, 16'd1})
            $display("FAIL frame_count_step: got %0d->%0d expected 0->1", cnt_at_tick, cnt_after);
        else n_pass++;
        n_total++;
        if ({vlow2, vf2x, vf2y} != {32'd1600, 32'd2, 32'd490})
            $display("FAIL vs_delayed: got low=%0d first=(%0d,%0d) expected 1600 (2,490)",
                     vlow2, vf2x, vf2y);
        else n_pass++;
        n_total++;
        if ({vlow0, vf0x, vf0y} != {32'd1600, 32'd0, 32'd490})
            $display("FAIL vs_nodelay: got low=%0d first=(%0d,%0d) expected 1600 (0,490)",
                     vlow0, vf0x, vf0y);
        else n_pass++;
        n_total++;
        if (vblank != 0) $display("FAIL vblank_blank: got %0d visible cycles expected 0", vblank);
        else n_pass++;
        n_total++;
        if ({max_x, max_y} != {32'd799, 32'd524})
            $display("FAIL counter_max: got (%0d,%0d) expected (799,524)", max_x, max_y);
        else n_pass++;
        n_total++;
        if (!(wrap_seen && wrap_ok))
            $display("FAIL wrap: got seen=%b ok=%b expected seen=1 ok=1", wrap_seen, wrap_ok);
        else n_pass++;
    endtask

    task automatic test_count_wrap();
        logic [15:0] c_tick = 16'hxxxx, c_after = 16'hxxxx;
        jump(479 * H_TOT + 700, 1'b1, 16'hFFFF);
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL wrap_model t=%0t: got %h expected %h", $time, obs_vec(), exp_vec());
            else n_pass++;
            if (tick2) c_tick = cnt2;
            if (x2 == 10'd1 && y2 == 10'd480) c_after = cnt2;
        end
        n_total++;
        if ({c_tick, c_after} !== {16'hFFFF, 16'h0000})
            $display("FAIL count_wrap: got %h->%h expected ffff->0000", c_tick, c_after);
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        bit found = 1'b0;
        int fx = -1, fy = -1;
        logic prev_hs;
        for (int i = 0; i < 1600 && !found; i++) begin
            @(negedge clk);
            if (!hs2 && x2 == 10'd700) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL mid_reset_setup: got no hs low at x=700 expected one");
        else n_pass++;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec() !== RST_VEC)
                $display("FAIL mid_reset_state: got %h expected %h", obs_vec(), RST_VEC);
            else n_pass++;
        end
        reset = 1'b0;
        prev_hs = hs2;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL post_reset_model t=%0t: got %h expected %h",
                         $time, obs_vec(), exp_vec());
            else n_pass++;
            if (prev_hs && !hs2 && fx < 0) begin fx = int'(x2); fy = int'(y2); end
            prev_hs = hs2;
        end
        n_total++;
        if ({fx, fy} != {32'd658, 32'd0})
            $display("FAIL post_reset_hs_fall: got (%0d,%0d) expected (658,0)", fx, fy);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int len = $urandom_range(200, 1500);
            int act = $urandom_range(0, 2);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                n_total++;
                if (obs_vec() !== exp_vec())
                    $display("FAIL random_model it=%0d t=%0t: got %h expected %h",
                             it, $time, obs_vec(), exp_vec());
                else n_pass++;
            end
            if (act == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    n_total++;
                    if (obs_vec() !== RST_VEC)
                        $display("FAIL random_reset it=%0d: got %h expected %h",
                                 it, obs_vec(), RST_VEC);
                    else n_pass++;
                end
                reset = 1'b0;
            end else if (act == 1) begin
                jump($urandom_range(1, F_TOT - 1), 1'b1, 16'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_cycle();
        test_line_sweep();
        test_frame_sweep();
        test_count_wrap();
        test_midframe_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
